serial_digit_chain_driver: RTL
==============================

Name: serial_digit_chain_driver

Overview:
- Parametrised serial driver for a chain of external 7-segment shift registers, e.g. 74HC595 style, one per digit.
- Fetches per-digit segment patterns in parallel from the upstream BCD/segment decoder via a digit-select handshake.
- Shifts each pattern out MSB-first on a generated serial clock, then pulses a storage latch once the whole frame is shifted.
- Supersedes the fixed 6-digit/8-bit controller; adds configurable depth and width, a start/busy handshake, continuous refresh, and a glitch-free registered serial clock. The serial clock is not gated from clk.

Parameters:
- NUM_DIGITS, 6: number of digits (shift-register stages) in the external chain; legal range 1..16.
- SEG_BITS, 8: bits per digit pattern (7 segments + DP); legal range 1..16.
- DIGIT_W, $clog2(NUM_DIGITS) (minimum 1): width of digit_sel.

Ports:
- clk, input, 1: system clock; all logic on posedge.
- reset_n, input, 1: asynchronous active-low reset.
- start, input, 1: request one frame; sampled in IDLE only.
- continuous, input, 1: when 1, the next frame begins immediately after the latch cycle.
- seg_data, input, SEG_BITS: pattern for digit_sel; sampled at the end of the LOAD cycle.
- digit_sel, output, DIGIT_W: index of the digit being fetched/shifted; 0 is shifted first.
- busy, output, 1: high from start acceptance through the LATCH cycle.
- ser_data, output, 1: serial data to the chain.
- ext_clk, output, 1: serial shift clock; the chain samples on its rising edge.
- ext_latch, output, 1: one-cycle storage latch pulse.
- frame_done, output, 1: one-cycle pulse, coincident with ext_latch.

Behaviour:
- Reset: all outputs registered and reset to 0. State, counters and the shift register are cleared. Reset is asynchronous and active-low, as already decided.
- FSM states: IDLE, LOAD, SHIFT, LATCH.
- IDLE:
  - busy=0.
  - start=1 or continuous=1 → LOAD, digit_sel=0, busy=1 from the next cycle.
- LOAD:
  - Lasts exactly 1 cycle; ext_clk=0.
  - The shift register captures seg_data at the end of the cycle.
  - Transition → SHIFT with bit_cnt=0, phase=0.
- SHIFT, 2 cycles per bit:
  - Phase 0: ser_data = sr[SEG_BITS-1], ext_clk=0.
  - Phase 1: ext_clk=1, ser_data held; at the end of phase 1 the register shifts left, zero fill, and bit_cnt increments.
  - After SEG_BITS bits: if digit_sel==NUM_DIGITS-1 → LATCH; else digit_sel+1 → LOAD.
- LATCH:
  - 1 cycle with ext_latch=1, frame_done=1, ext_clk=0.
  - Next state: continuous=1 → LOAD with digit_sel=0, busy stays 1; otherwise → IDLE, digit_sel=0.
- Frame length: NUM_DIGITS*(1+2*SEG_BITS)+1 cycles from first LOAD through LATCH inclusive. Defaults: 103 cycles.
- ser_data changes only while ext_clk=0, which gives half-period setup and hold.
- Handshake corner cases:
  - start while busy is ignored, not queued.
  - start and continuous both high in IDLE: one frame starts.
  - Deasserting continuous mid-frame completes the current frame, then returns to IDLE.
- Wrap-around: digit_sel never exceeds NUM_DIGITS-1. bit_cnt is SEG_BITS-bounded with no overflow.
- Reset mid-frame: immediate return to IDLE with all outputs 0. No ext_latch is issued, so the external display keeps the previous frame.
- ext_clk is never high in LOAD, LATCH or IDLE.

Optional Feature:
- Macro: SERIAL_CHAIN_BLANK_EN.
- Defined: adds input port blank (1 bit). If blank=1 is sampled in the LOAD cycle, the shift register loads all zeros instead of seg_data. Timing is unchanged, so a blanked frame still pulses ext_latch.
- Undefined: no blank port; seg_data is always loaded.

Test Plan:
- Reset/idle: reset_n=0 mid-SHIFT of digit 3 → all outputs 0 within the same cycle. After release, IDLE with busy=0 and no ext_latch ever seen.
- Single frame, defaults: pulse start with seg_data = 8'hA0+digit_sel → 48 ext_clk rising edges, then ext_latch at cycle 103. The captured bitstream is A0,A1,…,A5, MSB-first; frame_done coincides with ext_latch.
- Setup/hold: check that every ser_data transition occurs with ext_clk=0 and that ser_data is stable across each ext_clk rise.
- Continuous: hold continuous=1 for 3 frames → ext_latch pulses exactly 103 cycles apart, busy never drops, and no IDLE cycle appears. Drop continuous mid-frame 2 → frame 2 completes, then IDLE.
- Start while busy: extra start pulses at cycles 10 and 50 → only one frame and one ext_latch.
- Parameter sweep NUM_DIGITS=1, SEG_BITS=7: frame = 1*(1+14)+1 = 16 cycles, digit_sel stays 0, 7 ext_clk edges.
- With SERIAL_CHAIN_BLANK_EN: blank=1 during digit 2 LOAD → 8 zero bits in slot 2 and other digits unaffected.

Source files
------------

// File: rtl/serial_digit_chain_driver.sv
// Serial driver for a chain of 74HC595-style digit shift registers: fetch, shift MSB-first, latch.
// Optional SERIAL_CHAIN_BLANK_EN adds a 'blank' input that loads zeros instead of seg_data.
module serial_digit_chain_driver #(
    parameter int NUM_DIGITS = 6,
    parameter int SEG_BITS   = 8,
    parameter int DIGIT_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic                continuous,
    input  logic [SEG_BITS-1:0] seg_data,
`ifdef SERIAL_CHAIN_BLANK_EN
    input  logic                blank,
`endif
    output logic [DIGIT_W-1:0]  digit_sel,
    output logic                busy,
    output logic                ser_data,
    output logic                ext_clk,
    output logic                ext_latch,
    output logic                frame_done
);

    localparam int CNT_W = (SEG_BITS > 1) ? $clog2(SEG_BITS) : 1;
    localparam logic [CNT_W-1:0]   LAST_BIT   = CNT_W'(SEG_BITS - 1);
    localparam logic [DIGIT_W-1:0] LAST_DIGIT = DIGIT_W'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        LATCH = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [DIGIT_W-1:0]  digit_q, digit_d;
    logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic                phase_q, phase_d;
    logic [SEG_BITS-1:0] sr_q, sr_d;
    logic [SEG_BITS-1:0] load_val;

    logic busy_q, busy_d;
    logic ser_data_q, ser_data_d;
    logic ext_clk_q, ext_clk_d;
    logic ext_latch_q, ext_latch_d;
    logic frame_done_q, frame_done_d;

`ifdef SERIAL_CHAIN_BLANK_EN
    assign load_val = blank ? '0 : seg_data;
`else
    assign load_val = seg_data;
`endif

    always_comb begin
        state_d   = state_q;
        digit_d   = digit_q;
        bit_cnt_d = bit_cnt_q;
        phase_d   = phase_q;
        sr_d      = sr_q;
        case (state_q)
            IDLE: begin
                if (start || continuous) begin
                    state_d = LOAD;
                    digit_d = '0;
                end
            end
            LOAD: begin
                sr_d      = load_val;
                bit_cnt_d = '0;
                phase_d   = 1'b0;
                state_d   = SHIFT;
            end
            SHIFT: begin
                if (!phase_q) begin
                    phase_d = 1'b1;
                end else begin
                    // Falling edge of ext_clk: advance to the next bit
                    phase_d = 1'b0;
                    sr_d    = sr_q << 1;
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d = '0;
                        if (digit_q == LAST_DIGIT) begin
                            state_d = LATCH;
                        end else begin
                            digit_d = digit_q + DIGIT_W'(1);
                            state_d = LOAD;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
            end
            LATCH: begin
                digit_d = '0;
                state_d = continuous ? LOAD : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are decoded from next-state values so they can be registered without lag
    always_comb begin
        busy_d       = (state_d != IDLE);
        ext_clk_d    = (state_d == SHIFT) && phase_d;
        ser_data_d   = (state_d == SHIFT) ? sr_d[SEG_BITS-1] : 1'b0;
        ext_latch_d  = (state_d == LATCH);
        frame_done_d = (state_d == LATCH);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            digit_q      <= '0;
            bit_cnt_q    <= '0;
            phase_q      <= 1'b0;
            sr_q         <= '0;
            busy_q       <= 1'b0;
            ser_data_q   <= 1'b0;
            ext_clk_q    <= 1'b0;
            ext_latch_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            digit_q      <= digit_d;
            bit_cnt_q    <= bit_cnt_d;
            phase_q      <= phase_d;
            sr_q         <= sr_d;
            busy_q       <= busy_d;
            ser_data_q   <= ser_data_d;
            ext_clk_q    <= ext_clk_d;
            ext_latch_q  <= ext_latch_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign digit_sel  = digit_q;
    assign busy       = busy_q;
    assign ser_data   = ser_data_q;
    assign ext_clk    = ext_clk_q;
    assign ext_latch  = ext_latch_q;
    assign frame_done = frame_done_q;

endmodule
